// File: rtl/synchronous_fifo.sv
// 16-bit x 16-entry single-clock FIFO with registered read data and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add the overflow_o/underflow_o error pulses.
module synchronous_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  write_en_i,
  input  logic                  read_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  fifo_full_o,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow_o,
  output logic                  underflow_o,
`endif
  output logic                  fifo_empty_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] write_ptr;
  logic [ADDR_WIDTH-1:0] read_ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  full_q;
  logic                  empty_q;

  logic [ADDR_WIDTH-1:0] write_ptr_d;
  logic [ADDR_WIDTH-1:0] read_ptr_d;
  logic [CNT_W-1:0]      count_d;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  full_d;
  logic                  empty_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is judged against the registered flags, so no strobe-to-flag path exists.
  always_comb begin
    wr_acc      = write_en_i && !full_q;
    rd_acc      = read_en_i && !empty_q;
    write_ptr_d = write_ptr;
    read_ptr_d  = read_ptr;
    count_d     = count;
    data_out_d  = data_out_q;

    if (wr_acc) begin
      write_ptr_d = write_ptr + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      read_ptr_d = read_ptr + ADDR_WIDTH'(1);
      data_out_d = mem[read_ptr];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      count      <= '0;
      data_out_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      write_ptr  <= write_ptr_d;
      read_ptr   <= read_ptr_d;
      count      <= count_d;
      data_out_q <= data_out_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_acc) begin
      mem[write_ptr] <= data_in_i;
    end
  end

  assign data_out_o   = data_out_q;
  assign fifo_full_o  = full_q;
  assign fifo_empty_o = empty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= write_en_i && full_q;
      underflow_q <= read_en_i && empty_q;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed bench for synchronous_fifo: queue-based reference model checked every cycle,
// plus literal expectations for reset, fill, drain, simultaneous strobes, wrap and mid-op reset.
module tb_synchronous_fifo;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        write_en_i = 1'b0;
  logic        read_en_i = 1'b0;
  logic [15:0] data_in_i = '0;
  logic [15:0] data_out_o;
  logic        fifo_full_o;
  logic        fifo_empty_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic        overflow_o;
  logic        underflow_o;
`endif

  synchronous_fifo dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .write_en_i  (write_en_i),
    .read_en_i   (read_en_i),
    .data_in_i   (data_in_i),
    .data_out_o  (data_out_o),
    .fifo_full_o (fifo_full_o),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
`endif
    .fifo_empty_o(fifo_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus totals of accepted pushes/pops.
  logic [15:0] q[$];
  logic [15:0] exp_dout = '0;
  int          wr_total = 0;
  int          rd_total = 0;
  int          sz;
  bit          w_ok, r_ok;
  bit          exp_ovf = 1'b0, exp_unf = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      q.delete();
      exp_dout = '0;
      wr_total = 0;
      rd_total = 0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      sz      = q.size();
      w_ok    = write_en_i && (sz < 16);
      r_ok    = read_en_i && (sz > 0);
      exp_ovf = write_en_i && (sz == 16);
      exp_unf = read_en_i && (sz == 0);
      if (r_ok) begin
        exp_dout = q.pop_front();
        rd_total++;
      end
      if (w_ok) begin
        q.push_back(data_in_i);
        wr_total++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("dout", 32'(data_out_o), 32'(exp_dout));
      chk("full", 32'(fifo_full_o), 32'(q.size() == 16));
      chk("empty", 32'(fifo_empty_o), 32'(q.size() == 0));
      chk("count", 32'(dut.count), 32'(q.size()));
      chk("write_ptr", 32'(dut.write_ptr), 32'(wr_total % 16));
      chk("read_ptr", 32'(dut.read_ptr), 32'(rd_total % 16));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow", 32'(overflow_o), 32'(exp_ovf));
      chk("underflow", 32'(underflow_o), 32'(exp_unf));
`endif
    end
  end

  task automatic step(input logic w, input logic r, input logic [15:0] d);
    write_en_i = w;
    read_en_i  = r;
    data_in_i  = d;
    @(posedge clk_i);
    #1;
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] wr_words[10];
    int w0, r0;

    // Reset held for three edges
    rst_n_i = 1'b0;
    repeat (3) step(1'b0, 1'b0, 16'h0);
    rst_n_i = 1'b1;
    chk_en  = 1'b1;
    chk("rst_empty", 32'(fifo_empty_o), 32'd1);
    chk("rst_full", 32'(fifo_full_o), 32'd0);
    chk("rst_dout", 32'(data_out_o), 32'd0);
    chk("rst_wptr", 32'(dut.write_ptr), 32'd0);
    chk("rst_rptr", 32'(dut.read_ptr), 32'd0);

    // Fill to 16, then an overflowing write
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h1000 + 16'(i));
    chk("fill_full", 32'(fifo_full_o), 32'd1);
    chk("fill_wptr", 32'(dut.write_ptr), 32'd0);
    step(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_count", 32'(dut.count), 32'd16);
    chk("ovf_wptr", 32'(dut.write_ptr), 32'd0);

    // Drain 17 times
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("drain_dout", 32'(data_out_o), 32'h1000 + 32'(i));
    end
    chk("drain_empty", 32'(fifo_empty_o), 32'd1);
    step(1'b0, 1'b1, 16'h0);
    chk("unf_dout", 32'(data_out_o), 32'h100F);

    // Simultaneous strobes at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h2000 + 16'(i));
    w0 = 32'(dut.write_ptr);
    r0 = 32'(dut.read_ptr);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'h3000 + 16'(i));
      chk("both_dout", 32'(data_out_o), 32'h2000 + 32'(i));
    end
    chk("both_count", 32'(dut.count), 32'd5);
    chk("both_wptr", 32'(dut.write_ptr), 32'((w0 + 4) % 16));
    chk("both_rptr", 32'(dut.read_ptr), 32'((r0 + 4) % 16));
    step(1'b0, 1'b1, 16'h0);
    chk("both_order0", 32'(data_out_o), 32'h2004);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("both_order", 32'(data_out_o), 32'h3000 + 32'(i));
    end

    // Both strobes while empty: write only
    step(1'b1, 1'b1, 16'h4444);
    chk("empty_both_count", 32'(dut.count), 32'd1);
    chk("empty_both_dout", 32'(data_out_o), 32'h3003);
    step(1'b0, 1'b1, 16'h0);
    chk("empty_both_read", 32'(data_out_o), 32'h4444);

    // Both strobes while full: read only, write dropped
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h6000 + 16'(i));
    step(1'b1, 1'b1, 16'hBEEF);
    chk("full_both_count", 32'(dut.count), 32'd15);
    chk("full_both_dout", 32'(data_out_o), 32'h6000);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("full_both_drain", 32'(data_out_o), 32'h6000 + 32'(i));
    end
    chk("full_both_empty", 32'(fifo_empty_o), 32'd1);

    // Three wrap rounds of 10 random words
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 10; i++) begin
        wr_words[i] = 16'($urandom);
        step(1'b1, 1'b0, wr_words[i]);
      end
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b1, 16'h0);
        chk("wrap_data", 32'(data_out_o), 32'(wr_words[i]));
      end
    end

    // Mid-operation reset with 7 words stored
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h7000 + 16'(i));
    step(1'b0, 1'b1, 16'h0);
    rst_n_i = 1'b0;
    step(1'b1, 1'b1, 16'h1111);
    rst_n_i = 1'b1;
    chk("mid_rst_empty", 32'(fifo_empty_o), 32'd1);
    chk("mid_rst_wptr", 32'(dut.write_ptr), 32'd0);
    chk("mid_rst_rptr", 32'(dut.read_ptr), 32'd0);
    chk("mid_rst_dout", 32'(data_out_o), 32'd0);
    step(1'b1, 1'b0, 16'h5A5A);
    step(1'b0, 1'b1, 16'h0);
    chk("mid_rst_rw", 32'(data_out_o), 32'h5A5A);
    chk("mid_rst_final_empty", 32'(fifo_empty_o), 32'd1);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
